hazard_ctrl_unit: RTL and testbench
===================================

Name: hazard_ctrl_unit

Overview:
- Central hazard and pipeline-control block for the 5-stage MIPS-style core.
- Generates the stall and flush controls consumed by the F/D, D/X and X/M pipeline registers and the PC register.
- Detects load-use hazards in Decode, resolves taken-branch/jump flushes from Execute, freezes the pipe during instruction- or data-memory wait states, and latches halt.
- Keeps saturating performance counters for stall and flush cycles.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- REG_W, 3, register-select width (8 architectural registers).

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- regSelRs_D  in  REG_W  Rs select of the instruction in Decode
- regSelRt_D  in  REG_W  Rt select of the instruction in Decode
- rsUsed_D  in  1  Decode instruction reads Rs
- rtUsed_D  in  1  Decode instruction reads Rt
- writeRegSel_X  in  REG_W  destination register of the instruction in Execute
- writeEn_X  in  1  Execute instruction writes the register file
- memRead_X  in  1  Execute instruction is a load
- branchTaken_X  in  1  branch/jump resolved taken in Execute (single-cycle pulse)
- imemStall  in  1  instruction memory not ready
- dmemStall  in  1  data memory not ready
- halt_M  in  1  HALT instruction has reached Memory
- stall_PC  out  1  hold the PC
- stall_FD  out  1  hold the F/D register
- stall_DX  out  1  hold the D/X register
- stall_XM  out  1  hold the X/M register
- flush_FD  out  1  load a NOP into F/D
- flush_DX  out  1  load a NOP into D/X
- halted  out  1  core halted (sticky)
- stallCount  out  CNT_W  cycles in which stall_PC was asserted
- flushCount  out  CNT_W  cycles in which any flush was asserted

Behaviour:
- State machine (registered), 2-bit encoding: RUN, MEM_WAIT, HALTED.
- Reset (rst=0, asynchronous):
  - state=RUN, pendFlush=0, halted=0, both counters=0.
  - While rst=0: all stall outputs 0, flush_FD=flush_DX=1.
- Load-use hazard, combinational: luHaz = memRead_X & writeEn_X & ((rsUsed_D & regSelRs_D==writeRegSel_X) | (rtUsed_D & regSelRt_D==writeRegSel_X)).
- RUN outputs, evaluated in priority order; exactly one case applies:
  1. halt_M: all stall outputs=1, no flush. Next state HALTED, halted=1 from the next cycle.
  2. imemStall | dmemStall: all stall outputs=1, no flush. Next state MEM_WAIT. If branchTaken_X is high in this cycle, set pendFlush=1.
  3. branchTaken_X: flush_FD=1, flush_DX=1, no stalls. Overrides luHaz because the Decode instruction is squashed.
  4. luHaz: stall_PC=1, stall_FD=1, flush_DX=1 (one bubble). Exactly one cycle per hazard, because the load advances to M the next cycle.
  5. Otherwise all outputs 0.
- MEM_WAIT:
  - All stall outputs=1, no flush.
  - Leave to RUN in the first cycle with imemStall=0 and dmemStall=0; that cycle's outputs are RUN outputs.
  - If pendFlush=1, the exit cycle asserts flush_FD=flush_DX=1 with no stalls, and clears pendFlush. The pending flush takes priority over luHaz and over a new branchTaken_X.
  - halt_M seen in MEM_WAIT moves the state to HALTED, and halt takes priority.
- HALTED: all stall outputs=1, no flush. The state is left only by reset.
- Counters:
  - stallCount increments in every cycle with stall_PC=1.
  - flushCount increments in every cycle with flush_FD|flush_DX=1.
  - Both saturate at all-ones and never wrap.
  - Neither counts while rst=0.
- Latency: every stall and flush output is a same-cycle combinational function of the state and inputs. The state, pendFlush and counters take effect the cycle after the edge.
- A register-0 destination is not special-cased; the register file handles r0.

Decomposition:
- Package hazard_pkg:
  - state enum (RUN=2'd0, MEM_WAIT=2'd1, HALTED=2'd2).
  - NOP_OP constant 7'b0000100, shared with the pipeline registers.
  - REG_W default.
- Sub-module sat_counter (CNT_W, inc, out) with async active-low reset, instantiated twice.

Test Plan:
- Load-use: memRead_X=1, writeEn_X=1, writeRegSel_X=3, regSelRs_D=3, rsUsed_D=1 -> one cycle of stall_PC=stall_FD=flush_DX=1; next cycle all 0; stallCount=1.
- Branch beats load-use: luHaz true and branchTaken_X=1 -> flush_FD=flush_DX=1, stall_PC=0; flushCount=1.
- Branch during memory stall: dmemStall=1 for 3 cycles with branchTaken_X=1 in the first -> 3 cycles of all stalls=1, then 1 cycle of flush_FD=flush_DX=1, then idle; stallCount=3, flushCount=1.
- Halt: halt_M=1 -> halted=1 next cycle, stalls held high for 10+ cycles with input noise; asynchronous rst=0 mid-cycle -> immediate flush_FD=flush_DX=1, stalls=0, counters=0.
- Saturation: CNT_W=4 override, imemStall held 20 cycles -> stallCount reaches 4'hF and holds.
- No hazard: rsUsed_D=0 with matching regSelRs_D -> all outputs 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Types and constants shared by the hazard controller and the pipeline registers.
// The state encoding is fixed at 2 bits so that the illegal code 2'd3 stays visible to the default arm.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } hz_state_t;

  localparam int         DEF_REG_W = 3;
  localparam logic [6:0] NOP_OP    = 7'b0000100;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter: counts cycles with inc high and sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] out
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_full;

  assign w_full = (r_cnt == {CNT_W{1'b1}});

  // Count register; holds once saturated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (inc && !w_full) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign out = r_cnt;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Stall/flush generation for the 5-stage pipe: load-use bubbles, taken-branch squashes,
// memory wait-state freezes, sticky halt, and saturating stall/flush cycle counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int REG_W = DEF_REG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] regSelRs_D,
  input  logic [REG_W-1:0] regSelRt_D,
  input  logic             rsUsed_D,
  input  logic             rtUsed_D,
  input  logic [REG_W-1:0] writeRegSel_X,
  input  logic             writeEn_X,
  input  logic             memRead_X,
  input  logic             branchTaken_X,
  input  logic             imemStall,
  input  logic             dmemStall,
  input  logic             halt_M,
  output logic             stall_PC,
  output logic             stall_FD,
  output logic             stall_DX,
  output logic             stall_XM,
  output logic             flush_FD,
  output logic             flush_DX,
  output logic             halted,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);

  hz_state_t r_state;
  hz_state_t w_state_nxt;
  logic      r_pend_flush;
  logic      w_pend_nxt;
  logic      r_halted;

  logic w_lu_haz;
  logic w_mem_stall;
  logic w_run_eval;
  logic w_stall_all;
  logic w_lu_stall;
  logic w_flush_fd;
  logic w_flush_dx;

  assign w_mem_stall = imemStall | dmemStall;

  assign w_lu_haz = memRead_X & writeEn_X &
                    ((rsUsed_D & (regSelRs_D == writeRegSel_X)) |
                     (rtUsed_D & (regSelRt_D == writeRegSel_X)));

  // Next-state and control decode; the MEM_WAIT exit cycle falls through to the RUN priority chain.
  always_comb begin
    w_stall_all = 1'b0;
    w_lu_stall  = 1'b0;
    w_flush_fd  = 1'b0;
    w_flush_dx  = 1'b0;
    w_run_eval  = 1'b0;
    w_state_nxt = r_state;
    w_pend_nxt  = r_pend_flush;
    if (!rst) begin
      w_flush_fd = 1'b1;
      w_flush_dx = 1'b1;
    end else begin
      case (r_state)
        RUN: begin
          w_run_eval = 1'b1;
        end
        MEM_WAIT: begin
          if (halt_M) begin
            w_stall_all = 1'b1;
            w_state_nxt = HALTED;
          end else if (w_mem_stall) begin
            w_stall_all = 1'b1;
          end else if (r_pend_flush) begin
            // Branch resolved while frozen: squash now, ahead of any new hazard.
            w_flush_fd  = 1'b1;
            w_flush_dx  = 1'b1;
            w_pend_nxt  = 1'b0;
            w_state_nxt = RUN;
          end else begin
            w_state_nxt = RUN;
            w_run_eval  = 1'b1;
          end
        end
        HALTED: begin
          w_stall_all = 1'b1;
        end
        default: begin
          w_stall_all = 1'b1;
          w_state_nxt = RUN;
        end
      endcase

      if (w_run_eval) begin
        if (halt_M) begin
          w_stall_all = 1'b1;
          w_state_nxt = HALTED;
        end else if (w_mem_stall) begin
          w_stall_all = 1'b1;
          w_state_nxt = MEM_WAIT;
          w_pend_nxt  = branchTaken_X ? 1'b1 : r_pend_flush;
        end else if (branchTaken_X) begin
          w_flush_fd = 1'b1;
          w_flush_dx = 1'b1;
        end else if (w_lu_haz) begin
          w_lu_stall = 1'b1;
          w_flush_dx = 1'b1;
        end else begin
          w_lu_stall = 1'b0;
        end
      end else begin
        w_lu_stall = w_lu_stall;
      end
    end
  end

  // Controller state, pending-flush flag and sticky halt flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= RUN;
      r_pend_flush <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pend_flush <= w_pend_nxt;
      r_halted     <= r_halted | (w_state_nxt == HALTED);
    end
  end

  assign stall_PC = w_stall_all | w_lu_stall;
  assign stall_FD = w_stall_all | w_lu_stall;
  assign stall_DX = w_stall_all;
  assign stall_XM = w_stall_all;
  assign flush_FD = w_flush_fd;
  assign flush_DX = w_flush_dx;
  assign halted   = r_halted;

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (stall_PC),
    .out   (stallCount)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst),
    .inc   (flush_FD | flush_DX),
    .out   (flushCount)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: vector table plus hand-built multi-cycle sequences,
// with expected outputs queued at drive time and popped when sampled on the falling edge.
module tb_hazard_ctrl_unit;

  typedef struct packed {
    logic [2:0] rs;
    logic [2:0] rt;
    logic       ru;
    logic       tu;
    logic [2:0] ws;
    logic       we;
    logic       mr;
    logic       br;
    logic       im;
    logic       dm;
    logic       h;
  } in_t;

  typedef struct packed {
    logic halted;
    logic spc;
    logic sfd;
    logic sdx;
    logic sxm;
    logic ffd;
    logic fdx;
  } out_t;

  typedef struct {
    in_t   vin;
    out_t  vexp;
    string name;
  } vec_t;

  localparam out_t O_IDLE   = 7'b0000000;
  localparam out_t O_LU     = 7'b0110001;
  localparam out_t O_BR     = 7'b0000011;
  localparam out_t O_STALL  = 7'b0111100;
  localparam out_t O_HSTALL = 7'b1111100;
  localparam out_t O_RST    = 7'b0000011;

  logic        clk;
  logic        rst;
  logic [2:0]  regSelRs_D, regSelRt_D, writeRegSel_X;
  logic        rsUsed_D, rtUsed_D, writeEn_X, memRead_X, branchTaken_X;
  logic        imemStall, dmemStall, halt_M;
  logic        stall_PC, stall_FD, stall_DX, stall_XM, flush_FD, flush_DX, halted;
  logic [15:0] stallCount, flushCount;
  logic        s4_pc, s4_fd, s4_dx, s4_xm, f4_fd, f4_dx, h4;
  logic [3:0]  stallCount4, flushCount4;

  int   n_pass = 0;
  int   n_total = 0;
  int   m_sc = 0;
  int   m_fc = 0;
  out_t exp_q[$];
  vec_t tbl[11];

  hazard_ctrl_unit u_dut (
    .clk(clk), .rst(rst),
    .regSelRs_D(regSelRs_D), .regSelRt_D(regSelRt_D),
    .rsUsed_D(rsUsed_D), .rtUsed_D(rtUsed_D),
    .writeRegSel_X(writeRegSel_X), .writeEn_X(writeEn_X), .memRead_X(memRead_X),
    .branchTaken_X(branchTaken_X), .imemStall(imemStall), .dmemStall(dmemStall),
    .halt_M(halt_M),
    .stall_PC(stall_PC), .stall_FD(stall_FD), .stall_DX(stall_DX), .stall_XM(stall_XM),
    .flush_FD(flush_FD), .flush_DX(flush_DX), .halted(halted),
    .stallCount(stallCount), .flushCount(flushCount)
  );

  hazard_ctrl_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .regSelRs_D(regSelRs_D), .regSelRt_D(regSelRt_D),
    .rsUsed_D(rsUsed_D), .rtUsed_D(rtUsed_D),
    .writeRegSel_X(writeRegSel_X), .writeEn_X(writeEn_X), .memRead_X(memRead_X),
    .branchTaken_X(branchTaken_X), .imemStall(imemStall), .dmemStall(dmemStall),
    .halt_M(halt_M),
    .stall_PC(s4_pc), .stall_FD(s4_fd), .stall_DX(s4_dx), .stall_XM(s4_xm),
    .flush_FD(f4_fd), .flush_DX(f4_dx), .halted(h4),
    .stallCount(stallCount4), .flushCount(flushCount4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input logic [2:0] rs, input logic [2:0] rt, input logic ru,
                             input logic tu, input logic [2:0] ws, input logic we,
                             input logic mr, input logic br, input logic im,
                             input logic dm, input logic h);
    in_t v;
    v.rs = rs; v.rt = rt; v.ru = ru; v.tu = tu; v.ws = ws;
    v.we = we; v.mr = mr; v.br = br; v.im = im; v.dm = dm; v.h = h;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o = {halted, stall_PC, stall_FD, stall_DX, stall_XM, flush_FD, flush_DX};
    return o;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input in_t v);
    regSelRs_D = v.rs; regSelRt_D = v.rt; rsUsed_D = v.ru; rtUsed_D = v.tu;
    writeRegSel_X = v.ws; writeEn_X = v.we; memRead_X = v.mr; branchTaken_X = v.br;
    imemStall = v.im; dmemStall = v.dm; halt_M = v.h;
  endtask

  // One cycle: check counters accumulated so far, drive, then compare outputs mid-cycle.
  task automatic step(input in_t vin, input out_t vexp, input string nm);
    out_t got;
    out_t want;
    @(posedge clk);
    #1;
    check({nm, ":stallCount"}, 32'(stallCount), 32'(m_sc));
    check({nm, ":flushCount"}, 32'(flushCount), 32'(m_fc));
    check({nm, ":stallCount4"}, 32'(stallCount4), 32'((m_sc > 15) ? 15 : m_sc));
    drive(vin);
    exp_q.push_back(vexp);
    @(negedge clk);
    got  = sample();
    want = exp_q.pop_front();
    check({nm, ":outs"}, 32'(got), 32'(want));
    if (vexp.spc && m_sc < 65535) m_sc++;
    if ((vexp.ffd || vexp.fdx) && m_fc < 65535) m_fc++;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must react without waiting for a clock.
  task automatic do_reset(input string nm);
    @(negedge clk);
    #2;
    drive(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    rst = 1'b0;
    #1;
    check({nm, ":rst_outs"}, 32'(sample()), 32'(O_RST));
    check({nm, ":rst_stallCount"}, 32'(stallCount), 32'd0);
    check({nm, ":rst_flushCount"}, 32'(flushCount), 32'd0);
    m_sc = 0;
    m_fc = 0;
    @(negedge clk);
    #2;
    rst = 1'b1;
  endtask

  in_t idle_v, lu_v, lubr_v, noise_v;
  logic [31:0] rnd;

  initial begin
    rst = 1'b0;
    idle_v  = mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    lu_v    = mk(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    lubr_v  = mk(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(idle_v);

    tbl[0]  = '{idle_v, O_IDLE, "idle"};
    tbl[1]  = '{lu_v, O_LU, "lu_rs"};
    tbl[2]  = '{mk(3'd1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_LU, "lu_rt"};
    tbl[3]  = '{mk(3'd3, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_IDLE, "rs_unused"};
    tbl[4]  = '{mk(3'd0, 3'd4, 1'b0, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_IDLE, "rt_mismatch"};
    tbl[5]  = '{mk(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), O_IDLE, "not_load"};
    tbl[6]  = '{mk(3'd3, 3'd0, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_IDLE, "no_wr_en"};
    tbl[7]  = '{mk(3'd0, 3'd7, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_LU, "lu_r0"};
    tbl[8]  = '{mk(3'd2, 3'd6, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), O_BR, "branch"};
    tbl[9]  = '{lubr_v, O_BR, "branch_over_lu"};
    tbl[10] = '{mk(3'd1, 3'd2, 1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0), O_LU, "lu_rt_both_used"};

    do_reset("init");
    for (int i = 0; i < 11; i++) step(tbl[i].vin, tbl[i].vexp, tbl[i].name);
    step(idle_v, O_IDLE, "tbl_tail");

    do_reset("lu");
    step(lu_v, O_LU, "lu_bubble");
    step(idle_v, O_IDLE, "lu_release");
    check("lu_stallCount_is_1", 32'(stallCount), 32'd1);

    do_reset("brlu");
    step(lubr_v, O_BR, "brlu_flush");
    step(idle_v, O_IDLE, "brlu_after");
    check("brlu_flushCount_is_1", 32'(flushCount), 32'd1);
    check("brlu_stallCount_is_0", 32'(stallCount), 32'd0);

    do_reset("memflush");
    step(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0), O_STALL, "mw_enter_br");
    step(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), O_STALL, "mw_hold1");
    step(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0), O_STALL, "mw_hold2");
    step(lubr_v, O_BR, "mw_exit_pending_flush");
    step(idle_v, O_IDLE, "mw_idle");
    check("mw_stallCount_is_3", 32'(stallCount), 32'd3);
    check("mw_flushCount_is_1", 32'(flushCount), 32'd1);
    step(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), O_STALL, "mw2_enter");
    step(lu_v, O_LU, "mw2_exit_lu");
    step(idle_v, O_IDLE, "mw2_idle");
    step(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), O_STALL, "mw3_enter");
    step(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1), O_STALL, "mw3_halt");
    step(idle_v, O_HSTALL, "mw3_halted");

    do_reset("halt");
    step(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), O_STALL, "halt_enter");
    for (int k = 0; k < 12; k++) begin
      rnd = $urandom;
      noise_v = rnd[16:0];
      step(noise_v, O_HSTALL, "halt_noise");
    end
    check("halt_stallCount_is_12", 32'(stallCount), 32'd12);

    do_reset("sat");
    for (int k = 0; k < 20; k++) begin
      step(mk(3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0), O_STALL, "sat_imem");
    end
    step(idle_v, O_IDLE, "sat_exit");
    check("sat_stallCount4_is_F", 32'(stallCount4), 32'hF);
    check("sat_stallCount16_is_20", 32'(stallCount), 32'd20);
    step(idle_v, O_IDLE, "sat_hold");
    check("sat_stallCount4_holds_F", 32'(stallCount4), 32'hF);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
